// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned NumReq = 4;
    localparam int unsigned PtrW   = $clog2(NumReq);

    function automatic logic [NumReq-1:0] onehot(input logic [PtrW-1:0] idx);
        logic [NumReq-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fixed_prio_arbiter.sv
// Combinational fixed-priority picker: lowest set index of req wins, one-hot grant.
module fixed_prio_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    // Two's-complement trick isolates the lowest set bit.
    always_comb begin
        grant = req & (~req + N'(1));
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// N-requester round-robin arbiter with registered one-hot grant.
// Define RR_ARB_HOLD_EN to let the current owner keep the grant while it still requests.
module round_robin_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned N = NumReq
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  mask, req_masked, gnt_masked, gnt_plain, gnt_sel;

    // Bits at or above the pointer get first chance.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask[i] = (i >= 32'(ptr_q));
        end
        req_masked = req & mask;
    end

    fixed_prio_arbiter #(.N(N)) u_masked (
        .req   (req_masked),
        .grant (gnt_masked)
    );

    fixed_prio_arbiter #(.N(N)) u_plain (
        .req   (req),
        .grant (gnt_plain)
    );

    always_comb begin
        gnt_sel = (|gnt_masked) ? gnt_masked : gnt_plain;
        grant_d = gnt_sel;
        ptr_d   = ptr_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_sel[i]) begin
                ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
`ifdef RR_ARB_HOLD_EN
        // Owner still requesting: park; ptr already points past it.
        if (|(grant_q & req)) begin
            grant_d = grant_q;
            ptr_d   = ptr_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter: directed steps then randomized traffic.
module tb_round_robin_arbiter;
    import rr_arb_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] grant;

    int checks = 0;
    int fails  = 0;

    // Reference model state: priority index and current owner (-1 = none).
    int           m_ptr   = 0;
    int           m_owner = -1;
    logic [N-1:0] m_grant = '0;

    round_robin_arbiter #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    always #5 clk = ~clk;

    task automatic model(input logic r, input logic [N-1:0] rq);
        if (r) begin
            m_grant = '0;
            m_ptr   = 0;
            m_owner = -1;
            return;
        end
`ifdef RR_ARB_HOLD_EN
        if (m_owner >= 0 && rq[m_owner]) return;
`endif
        m_grant = '0;
        m_owner = -1;
        for (int j = 0; j < N; j++) begin
            int k;
            k = (m_ptr + j) % N;
            if (rq[k]) begin
                m_grant[k] = 1'b1;
                m_owner    = k;
                m_ptr      = (k + 1) % N;
                break;
            end
        end
    endtask

    task automatic check(input string tag, input logic [N-1:0] exp);
        checks++;
        assert (grant === exp) else begin
            fails++;
            $error("FAIL %s: grant=%b expected=%b", tag, grant, exp);
        end
    endtask

    // Drive one cycle, advance the model at the edge, sample 1 time unit later.
    task automatic cycle(input logic r, input logic [N-1:0] rq);
        rst = r;
        req = rq;
        @(posedge clk);
        model(r, rq);
        #1;
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] exp,
                        input string tag);
        cycle(r, rq);
        check(tag, exp);
    endtask

    initial begin
        logic [N-1:0] held;
        rst = 1'b1;
        req = '0;
        @(negedge clk);

        step(1'b1, 4'b1111, 4'b0000, "reset0");
        step(1'b1, 4'b1111, 4'b0000, "reset1");

`ifndef RR_ARB_HOLD_EN
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b1111, onehot(PtrW'(i % 4)), "full_rotate");
        end
        step(1'b0, 4'b0001, 4'b0001, "single0");
        step(1'b0, 4'b0010, 4'b0010, "single1");
        step(1'b0, 4'b0100, 4'b0100, "single2");
        step(1'b0, 4'b1000, 4'b1000, "single3");
        step(1'b0, 4'b0001, 4'b0001, "single0b");
        step(1'b0, 4'b0100, 4'b0100, "set_ptr3");
        step(1'b0, 4'b1011, 4'b1000, "partial_a");
        step(1'b0, 4'b1011, 4'b0001, "partial_b");
        step(1'b0, 4'b1011, 4'b0010, "partial_c");
        step(1'b0, 4'b1011, 4'b1000, "partial_d");
        step(1'b0, 4'b0010, 4'b0010, "set_ptr2");
        step(1'b0, 4'b0000, 4'b0000, "idle");
        step(1'b0, 4'b0011, 4'b0001, "after_idle");
        // ptr is now 1; reset must bring it back to 0.
        step(1'b1, 4'b1111, 4'b0000, "mid_reset");
        step(1'b0, 4'b0011, 4'b0001, "ptr_after_reset");
`else
        step(1'b0, 4'b1111, 4'b0001, "hold_first");
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 4'b0001, "hold_park");
        step(1'b0, 4'b1110, 4'b0010, "hold_release");
        step(1'b0, 4'b1110, 4'b0010, "hold_park1");
        step(1'b0, 4'b0110, 4'b0010, "hold_park1b");
        step(1'b0, 4'b0100, 4'b0100, "hold_resume");
        step(1'b0, 4'b0000, 4'b0000, "hold_idle");
        step(1'b1, 4'b1111, 4'b0000, "mid_reset");
        step(1'b0, 4'b1010, 4'b0010, "ptr_after_reset");
`endif

        // Grant is registered: changing req mid-cycle must not disturb it.
        step(1'b0, 4'b1000, 4'b1000, "pre_comb");
        held = grant;
        req  = 4'b0111;
        #2;
        check("no_comb_path", held);

        for (int i = 0; i < 400; i++) begin
            logic         r;
            logic [N-1:0] rq;
            r  = ($urandom_range(0, 39) == 0);
            rq = N'($urandom);
            if ($urandom_range(0, 3) == 0) rq = 4'b1111;
            cycle(r, rq);
            check("random", m_grant);
            checks++;
            assert ($onehot0(grant)) else begin
                fails++;
                $error("FAIL onehot: grant=%b expected=one-hot or zero", grant);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
